// File: rtl/dvp_frame_gen.sv
// DVP frame source: vsync/href/data timing with configurable geometry, blanking
// and test patterns, single-shot or continuous.
module dvp_frame_gen #(
  parameter int WIDTH      = 24,
  parameter int HEIGHT     = 16,
  parameter int BPP        = 2,
  parameter int DATA_W     = 8,
  parameter int VSYNC_LEN  = 10,
  parameter int VBP_LEN    = 20,
  parameter int HBLANK_LEN = 10,
  parameter int VFP_LEN    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] const_val,
  output logic              vsync,
  output logic              href,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_cnt
);

  if (WIDTH < 1 || HEIGHT < 1 || BPP < 1 || BPP > 4 || DATA_W < 1 ||
      VSYNC_LEN < 1 || VBP_LEN < 1 || HBLANK_LEN < 1 || VFP_LEN < 1) begin : g_param_check
    $error("dvp_frame_gen: illegal parameter value");
  end

  localparam int unsigned MAX_A   = (VSYNC_LEN > VBP_LEN) ? VSYNC_LEN : VBP_LEN;
  localparam int unsigned MAX_B   = (HBLANK_LEN > VFP_LEN) ? HBLANK_LEN : VFP_LEN;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned XW      = $clog2(WIDTH + 1);
  localparam int unsigned YW      = $clog2(HEIGHT + 1);
  localparam int unsigned BW      = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBP, S_LINE, S_HBLANK, S_VFP
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [BW-1:0]     b, b_d;
  logic [XW-1:0]     x, x_d;
  logic [YW-1:0]     y, y_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] cv_q, cv_d;
  logic [15:0]       frame_cnt_d;
  logic              vsync_d, href_d, busy_d, done_d;
  logic [DATA_W-1:0] data_d;

  // Next state, counters, and the output values that go with the next state
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    b_d         = b;
    x_d         = x;
    y_d         = y;
    mode_d      = mode_q;
    cv_d        = cv_q;
    frame_cnt_d = frame_cnt;
    vsync_d     = 1'b0;
    href_d      = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    data_d      = '0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_VSYNC;
          cnt_d   = '0;
          mode_d  = mode;
          cv_d    = const_val;
        end
      end
      S_VSYNC: begin
        if (cnt == CNT_W'(VSYNC_LEN - 1)) begin
          state_d = S_VBP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_VBP: begin
        if (cnt == CNT_W'(VBP_LEN - 1)) begin
          state_d = S_LINE;
          cnt_d   = '0;
          b_d     = '0;
          x_d     = '0;
          y_d     = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_LINE: begin
        if (b == BW'(BPP - 1)) begin
          b_d = '0;
          if (x == XW'(WIDTH - 1)) begin
            state_d = S_HBLANK;
            x_d     = '0;
            cnt_d   = '0;
          end else begin
            x_d = x + XW'(1);
          end
        end else begin
          b_d = b + BW'(1);
        end
      end
      S_HBLANK: begin
        if (cnt == CNT_W'(HBLANK_LEN - 1)) begin
          cnt_d = '0;
          if (y == YW'(HEIGHT - 1)) begin
            state_d = S_VFP;
          end else begin
            state_d = S_LINE;
            y_d     = y + YW'(1);
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_VFP: begin
        if (cnt == CNT_W'(VFP_LEN - 1)) begin
          cnt_d       = '0;
          frame_cnt_d = frame_cnt + 16'd1;
          if (continuous) begin
            state_d = S_VSYNC;
            mode_d  = mode;
            cv_d    = const_val;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    vsync_d = (state_d == S_VSYNC);
    href_d  = (state_d == S_LINE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_VFP) && (cnt_d == CNT_W'(VFP_LEN - 1));

    // Checker tile bit ((x>>2)^(y>>2))&1 is bit 2 of x^y
    if (state_d == S_LINE) begin
      case (mode_d)
        2'd0:    data_d = cv_d + DATA_W'(b_d);
        2'd1:    data_d = DATA_W'(x_d) + DATA_W'(b_d);
        2'd2:    data_d = (((32'(x_d) ^ 32'(y_d)) & 32'd4) != 32'd0) ? '1 : '0;
        default: data_d = DATA_W'(frame_cnt_d) + DATA_W'(b_d);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      b          <= '0;
      x          <= '0;
      y          <= '0;
      mode_q     <= '0;
      cv_q       <= '0;
      frame_cnt  <= '0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      data       <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      b          <= b_d;
      x          <= x_d;
      y          <= y_d;
      mode_q     <= mode_d;
      cv_q       <= cv_d;
      frame_cnt  <= frame_cnt_d;
      vsync      <= vsync_d;
      href       <= href_d;
      data       <= data_d;
      busy       <= busy_d;
      frame_done <= done_d;
    end
  end

endmodule

// File: tb/tb_dvp_frame_gen.sv
// Bench for dvp_frame_gen: two geometries driven by shared stimulus, compared
// every cycle against a frame-position model.
module tb_dvp_frame_gen;

  localparam int VS  = 10;
  localparam int VBP = 20;
  localparam int HB  = 10;
  localparam int VFP = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] const_val = 8'd0;

  logic        vs [2];
  logic        hr [2];
  logic [7:0]  dat [2];
  logic        bz [2];
  logic        fd [2];
  logic [15:0] fcn [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dvp_frame_gen dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .mode(mode), .const_val(const_val),
    .vsync(vs[0]), .href(hr[0]), .data(dat[0]), .busy(bz[0]),
    .frame_done(fd[0]), .frame_cnt(fcn[0])
  );

  dvp_frame_gen #(.WIDTH(8), .HEIGHT(8), .BPP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .mode(mode), .const_val(const_val),
    .vsync(vs[1]), .href(hr[1]), .data(dat[1]), .busy(bz[1]),
    .frame_done(fd[1]), .frame_cnt(fcn[1])
  );

  typedef struct packed {
    logic        vs;
    logic        hr;
    logic [7:0]  dt;
    logic        bz;
    logic        fd;
    logic [15:0] fc;
  } exp_t;

  function automatic int gw(input int d); return (d == 0) ? 24 : 8; endfunction
  function automatic int gh(input int d); return (d == 0) ? 16 : 8; endfunction
  function automatic int gb(input int d); return (d == 0) ? 2 : 1;  endfunction
  function automatic int flen(input int d);
    return VS + VBP + gh(d) * (gw(d) * gb(d) + HB) + VFP;
  endfunction

  // Outputs implied by position p (1-based cycle index) within a running frame
  function automatic exp_t model_out(input int d, input bit run, input int p,
                                     input logic [1:0] md, input logic [7:0] cv,
                                     input logic [15:0] fc);
    exp_t e;
    int w, h, bp, lp, q, r, x, y, bb;
    e = '0;
    e.fc = fc;
    e.bz = run;
    w = gw(d); h = gh(d); bp = gb(d); lp = w * bp + HB;
    if (run) begin
      e.vs = (p <= VS);
      e.fd = (p == flen(d));
      q = p - VS - VBP - 1;
      if (q >= 0 && q < h * lp) begin
        y = q / lp;
        r = q % lp;
        if (r < w * bp) begin
          x = r / bp;
          bb = r % bp;
          e.hr = 1'b1;
          case (md)
            2'd0:    e.dt = cv + 8'(bb);
            2'd1:    e.dt = 8'(x + bb);
            2'd2:    e.dt = ((((x / 4) ^ (y / 4)) % 2) == 1) ? 8'hFF : 8'h00;
            default: e.dt = fc[7:0] + 8'(bb);
          endcase
        end
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  bit          armed = 1'b0;
  bit          m_run [2];
  int          m_p   [2];
  logic [15:0] m_fc  [2];
  logic [1:0]  m_md  [2];
  logic [7:0]  m_cv  [2];
  exp_t        ce;

  // Advance the model on each edge, then compare both DUTs just after it
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_run[d] = 1'b0; m_p[d] = 0; m_fc[d] = 16'd0; m_md[d] = 2'd0; m_cv[d] = 8'd0;
      end else if (!m_run[d]) begin
        if (start) begin
          m_run[d] = 1'b1; m_p[d] = 1; m_md[d] = mode; m_cv[d] = const_val;
        end
      end else if (m_p[d] == flen(d)) begin
        m_fc[d] = m_fc[d] + 16'd1;
        if (continuous) begin
          m_p[d] = 1; m_md[d] = mode; m_cv[d] = const_val;
        end else begin
          m_run[d] = 1'b0;
        end
      end else begin
        m_p[d] = m_p[d] + 1;
      end
    end
    if (!rst_n) armed = 1'b1;
    #1;
    if (armed) begin
      for (int d = 0; d < 2; d++) begin
        ce = model_out(d, m_run[d], m_p[d], m_md[d], m_cv[d], m_fc[d]);
        check($sformatf("vsync[%0d]", d), 32'(vs[d]), 32'(ce.vs));
        check($sformatf("href[%0d]", d), 32'(hr[d]), 32'(ce.hr));
        check($sformatf("data[%0d]", d), 32'(dat[d]), 32'(ce.dt));
        check($sformatf("busy[%0d]", d), 32'(bz[d]), 32'(ce.bz));
        check($sformatf("frame_done[%0d]", d), 32'(fd[d]), 32'(ce.fd));
        check($sformatf("frame_cnt[%0d]", d), 32'(fcn[d]), 32'(ce.fc));
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((bz[0] || bz[1]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", 32'({bz[0], bz[1]}), 32'd0);
  endtask

  exp_t pe;
  int   done_seen;

  initial begin
    // Hand-derived values that pin the model
    pe = model_out(0, 1'b1, 31, 2'd0, 8'd1, 16'd0);
    check("model_first_href", 32'({pe.hr, pe.dt}), 32'h101);
    pe = model_out(0, 1'b1, 949, 2'd0, 8'd1, 16'd0);
    check("model_hblank_after_last", 32'(pe.hr), 32'd0);
    pe = model_out(0, 1'b1, 968, 2'd0, 8'd1, 16'd0);
    check("model_done_968", 32'(pe.fd), 32'd1);
    pe = model_out(0, 1'b1, 252, 2'd1, 8'd0, 16'd0);
    check("model_ramp_line3_end", 32'(pe.dt), 32'd24);
    pe = model_out(1, 1'b1, 35, 2'd2, 8'd0, 16'd0);
    check("model_chk_l0_x4", 32'(pe.dt), 32'hFF);
    pe = model_out(1, 1'b1, 107, 2'd2, 8'd0, 16'd0);
    check("model_chk_l4_x4", 32'(pe.dt), 32'h00);

    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Mode 0 default timing with an ignored start at cycle 500
    mode = 2'd0; const_val = 8'd1;
    do_start();
    done_seen = 0;
    for (int k = 1; k <= 969; k++) begin
      start = (k == 500);
      case (k)
        1:   check("t1_vs_c1", 32'(vs[0]), 32'd1);
        10:  check("t1_vs_c10", 32'(vs[0]), 32'd1);
        11:  check("t1_vs_c11", 32'(vs[0]), 32'd0);
        30:  check("t1_href_c30", 32'(hr[0]), 32'd0);
        31:  check("t1_c31", 32'({hr[0], dat[0]}), 32'h101);
        32:  check("t1_c32", 32'({hr[0], dat[0]}), 32'h102);
        78:  check("t1_c78", 32'({hr[0], dat[0]}), 32'h102);
        79:  check("t1_c79", 32'({hr[0], dat[0]}), 32'h000);
        321: check("t1_line5_start", 32'(hr[0]), 32'd1);
        948: check("t1_last_href", 32'(hr[0]), 32'd1);
        949: check("t1_c949", 32'(hr[0]), 32'd0);
        968: check("t1_done_968", 32'(fd[0]), 32'd1);
        969: check("t1_c969", 32'({bz[0], fcn[0]}), 32'h00001);
        default: ;
      endcase
      if (fd[0]) done_seen++;
      @(negedge clk);
    end
    start = 1'b0;
    check("t1_single_done", 32'(done_seen), 32'd1);
    wait_idle(2000);

    // Mode 1 ramp, line 3
    mode = 2'd1; const_val = 8'h5A;
    do_start();
    for (int k = 1; k <= 253; k++) begin
      case (k)
        205: check("t2_l3_b0", 32'(dat[0]), 32'd0);
        206: check("t2_l3_b1", 32'(dat[0]), 32'd1);
        207: check("t2_l3_b2", 32'(dat[0]), 32'd1);
        252: check("t2_l3_last", 32'(dat[0]), 32'd24);
        253: check("t2_hblank", 32'({hr[0], dat[0]}), 32'd0);
        default: ;
      endcase
      @(negedge clk);
    end
    wait_idle(2000);

    // Mode 2 checker on the 8x8 instance
    mode = 2'd2;
    do_start();
    for (int k = 1; k <= 110; k++) begin
      if (k >= 31 && k <= 38)
        check("t3_chk_line0", 32'(dat[1]), (k >= 35) ? 32'hFF : 32'h00);
      if (k >= 103 && k <= 110)
        check("t3_chk_line4", 32'(dat[1]), (k < 107) ? 32'hFF : 32'h00);
      @(negedge clk);
    end
    wait_idle(2000);

    // Continuous mode 3 for three frames
    do_reset();
    mode = 2'd3; continuous = 1'b1;
    do_start();
    for (int k = 1; k <= 1000; k++) begin
      case (k)
        31:   check("t4_f1_b0", 32'(dat[0]), 32'd0);
        32:   check("t4_f1_b1", 32'(dat[0]), 32'd1);
        968:  check("t4_f1_done", 32'(fd[0]), 32'd1);
        969:  check("t4_vs_rerise", 32'({vs[0], fcn[0]}), 32'h10001);
        999:  check("t4_f2_b0", 32'(dat[0]), 32'd1);
        1000: check("t4_f2_b1", 32'(dat[0]), 32'd2);
        default: ;
      endcase
      @(negedge clk);
    end
    begin
      int n = 0;
      while (fcn[0] != 16'd2 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check("t4_reach_two", 32'(fcn[0]), 32'd2);
    end
    continuous = 1'b0;
    wait_idle(2000);
    check("t4_final_cnt", 32'(fcn[0]), 32'd3);

    // Reset mid-line, then a clean frame
    mode = 2'd0; const_val = 8'd1;
    do_start();
    for (int k = 1; k < 400; k++) @(negedge clk);
    check("t5_midline", 32'(hr[0]), 32'd1);
    do_reset();
    check("t5_after_rst", 32'({vs[0], hr[0], dat[0], bz[0], fd[0], fcn[0]}), 32'd0);
    repeat (5) @(negedge clk);
    do_start();
    for (int k = 1; k <= 969; k++) begin
      case (k)
        1:   check("t5_vs_c1", 32'(vs[0]), 32'd1);
        31:  check("t5_c31", 32'({hr[0], dat[0]}), 32'h101);
        968: check("t5_done", 32'(fd[0]), 32'd1);
        969: check("t5_end", 32'({bz[0], fcn[0]}), 32'h00001);
        default: ;
      endcase
      @(negedge clk);
    end
    wait_idle(2000);

    // Randomised frames: mode/const changes, stray starts, continuous, resets
    repeat (8) begin
      int n;
      mode = 2'($urandom);
      const_val = 8'($urandom);
      continuous = ($urandom_range(0, 2) == 0);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      do_start();
      n = $urandom_range(100, 2500);
      for (int i = 0; i < n; i++) begin
        start = ($urandom_range(0, 39) == 0);
        rst_n = ($urandom_range(0, 1499) != 0);
        if ($urandom_range(0, 99) == 0) mode = 2'($urandom);
        if ($urandom_range(0, 99) == 0) const_val = 8'($urandom);
        @(negedge clk);
      end
      start = 1'b0;
      rst_n = 1'b1;
      continuous = 1'b0;
      wait_idle(3000);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
